// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the program counter, issues word-aligned requests to instruction
// memory, and buffers returned words with their PCs in a small in-order FIFO.
// A redirect flushes buffered entries and marks in-flight responses as stale.
module fetch_unit #(
    parameter int unsigned     WORD     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,

    // instruction memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [WORD-1:0] imem_req_addr,

    // instruction memory response channel (no backpressure)
    input  logic            imem_resp_valid,
    input  logic [WORD-1:0] imem_resp_data,

    // branch/jump resolution
    input  logic            redirect_valid,
    input  logic [WORD-1:0] redirect_pc,

    // decode channel
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [WORD-1:0] inst,
    output logic [WORD-1:0] inst_pc
);

    // Counters hold 0..DEPTH inclusive; pointers index DEPTH entries and wrap
    // naturally because DEPTH is a power of two.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [WORD-1:0] ALIGN_MASK = ~WORD'(3);
    localparam logic [WORD-1:0] PC_STEP    = WORD'(4);
    localparam logic [WORD-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
    localparam logic [CW:0]     DEPTH_OCC  = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [WORD-1:0] inst;
    } entry_t;

    // architectural state
    logic [WORD-1:0] fetch_pc;
    logic [WORD-1:0] resp_pc;
    cnt_t            inflight;
    cnt_t            drop;
    cnt_t            count;
    ptr_t            rd_ptr;
    ptr_t            wr_ptr;
    entry_t          fifo_mem [DEPTH];

    // per-cycle decisions
    logic [CW:0]     occupancy;
    logic            credit;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic [WORD-1:0] redirect_aligned;
    entry_t          head;

    // Handshake decode: which events actually take effect this cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one
        // unassigned and infer a latch.
        occupancy        = '0;
        credit           = 1'b0;
        req_fire         = 1'b0;
        resp_fire        = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
        redirect_aligned = redirect_pc & ALIGN_MASK;

        // Requests already issued plus entries already buffered must leave a
        // FIFO slot for every response that can still come back.
        occupancy = {1'b0, inflight} + {1'b0, count};
        credit    = (occupancy < DEPTH_OCC);

        req_fire  = imem_req_valid && imem_req_ready;

        // A response with nothing outstanding is a protocol violation: ignore it.
        resp_fire = imem_resp_valid && (inflight != '0);

        // Responses are kept only when not stale and no redirect is flushing.
        push      = resp_fire && !redirect_valid && (drop == '0);

        // A redirect swallows any pop attempted in the same cycle.
        pop       = inst_valid && inst_ready && !redirect_valid;
    end

    // Requests are held off during reset and in the redirect cycle itself.
    assign imem_req_valid = reset && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc;

    // Program counters: redirect wins, otherwise advance on each handshake.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (!reset) begin
            fetch_pc <= RESET_PC_A;
            resp_pc  <= RESET_PC_A;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
                resp_pc <= resp_pc + PC_STEP;
            end
        end
    end

    // Outstanding-request counter; no request fires in a redirect cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + cnt_t'(req_fire) - cnt_t'(resp_fire);
        end
    end

    // Stale-response counter: on redirect every outstanding request except
    // one answered in the same cycle becomes stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop <= '0;
        end else if (redirect_valid) begin
            drop <= inflight - cnt_t'(resp_fire);
        end else if (resp_fire && (drop != '0)) begin
            drop <= drop - cnt_t'(1);
        end
    end

    // FIFO bookkeeping: pointers and occupancy, flushed by redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + cnt_t'(push) - cnt_t'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // FIFO storage write: responses land one cycle before they are visible.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count and the pointers decide
        // what is valid, so stale contents are never observed.
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: resp_pc, inst: imem_resp_data};
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign inst_valid = (count != '0);

    // Empty FIFO presents zeros so decode never sees uninitialised storage.
    assign inst    = inst_valid ? head.inst : '0;
    assign inst_pc = inst_valid ? head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a memory model and a
// scoreboard of expected {pc, inst} pairs popped as decode consumes them.
module tb_fetch_unit;

    localparam int unsigned     WORD     = 32;
    localparam int unsigned     DEPTH    = 4;
    localparam logic [WORD-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit #(
        .WORD     (WORD),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench model state
    exp_t        sb[$];
    logic [31:0] mem_q[$];
    int          stale;
    logic [31:0] exp_fetch;
    logic        mem_en;
    logic        const_mode;
    int          n_vec;
    int          n_err;
    int          cyc;
    int          req_cnt;
    int          first_req_cyc;
    int          first_val_cyc;
    logic        arm_first;
    logic [31:0] first_pop_pc;
    logic [31:0] last_req_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return const_mode ? 32'h0000_0013 : (a ^ 32'h5A5A_0F0F);
    endfunction

    // One clock cycle, entered and left at a falling edge with inputs set.
    task automatic cycle();
        logic [31:0] raddr;
        exp_t        e;
        raddr = '0;
        if (mem_en && mem_q.size() > 0) begin
            raddr           = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(raddr);
        end else begin
            imem_resp_valid = 1'b0;
        end
        #1;
        if (inst_valid === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
        if (redirect_valid) check("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (inst_valid && inst_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("inst_valid_unexpected", {31'b0, inst_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst", inst, e.inst);
                if (arm_first) begin
                    first_pop_pc = inst_pc;
                    arm_first    = 1'b0;
                end
            end
        end
        if (imem_resp_valid) begin
            if (redirect_valid) begin
                // flushed by the redirect
            end else if (stale > 0) begin
                stale--;
            end else begin
                sb.push_back('{pc: raddr, inst: imem_resp_data});
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fetch);
            mem_q.push_back(exp_fetch);
            last_req_addr = imem_req_addr;
            exp_fetch     = exp_fetch + 32'd4;
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (redirect_valid) begin
            sb.delete();
            stale     = mem_q.size();
            exp_fetch = redirect_pc & ~32'h3;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        imem_resp_valid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
        #1;
    endtask

    // Stop fetching and let every outstanding word reach decode.
    task automatic drain();
        int k;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        mem_en         = 1'b1;
        k = 0;
        while (k < 40 && !(mem_q.size() == 0 && sb.size() == 0 && inst_valid === 1'b0)) begin
            cycle();
            k++;
        end
        check("drain_sb_empty", sb.size(), 32'd0);
        check("drain_inst_valid", {31'b0, inst_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int k;
        n_vec = 0; n_err = 0; cyc = 0; req_cnt = 0; stale = 0;
        first_req_cyc = -1; first_val_cyc = -1;
        arm_first = 1'b0; first_pop_pc = '0; last_req_addr = '0;
        exp_fetch = RESET_PC; mem_en = 1'b1; const_mode = 1'b1;
        reset = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // streaming fetch with constant instruction word
        @(negedge clk);
        reset = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        repeat (12) cycle();
        check("first_valid_latency", first_val_cyc - first_req_cyc, 32'd2);
        drain();

        // backpressure: exactly DEPTH requests, then one per pop
        const_mode = 1'b0;
        do_redirect(32'h0);
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        start = req_cnt;
        repeat (8) cycle();
        #1;
        check("credit_req_count", req_cnt - start, DEPTH);
        check("credit_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        start = req_cnt;
        repeat (6) cycle();
        check("after_pop_req_count", req_cnt - start, 32'd1);
        check("after_pop_req_addr", last_req_addr, 32'h10);
        drain();

        // redirect with two stale requests in flight
        mem_en = 1'b0;
        do_redirect(32'h8);
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) cycle();
        do_redirect(32'h103);
        check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        mem_en = 1'b1; arm_first = 1'b1;
        repeat (10) cycle();
        check("redir_first_pc", first_pop_pc, 32'h100);
        drain();

        // redirect coinciding with a response and a pop
        do_redirect(32'h180);
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) cycle();
        check("pre_redirect_valid", {31'b0, inst_valid}, 32'd1);
        do_redirect(32'h200);
        check("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
        arm_first = 1'b1;
        repeat (6) cycle();
        check("flush_first_pc", first_pop_pc, 32'h200);
        drain();

        // address wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        imem_req_ready = 1'b1; inst_ready = 1'b1; arm_first = 1'b1;
        repeat (6) cycle();
        check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);
        drain();

        // reset asserted with three buffered entries
        do_redirect(32'h40);
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        start = req_cnt;
        k = 0;
        while (req_cnt - start < 3 && k < 10) begin
            cycle();
            k++;
        end
        imem_req_ready = 1'b0;
        repeat (2) cycle();
        check("prereset_inst_valid", {31'b0, inst_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("midrst_req_addr", imem_req_addr, RESET_PC);
        check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("midrst_inst_pc", inst_pc, 32'd0);
        sb.delete(); mem_q.delete(); stale = 0; exp_fetch = RESET_PC;
        repeat (2) @(negedge clk);
        reset = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        check("rerun_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rerun_req_addr", imem_req_addr, RESET_PC);
        repeat (6) cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
